// File: rtl/fpu_bank_pkg.sv
// rtl/fpu_bank_pkg.sv - lane state, job descriptor types and round-robin pick helper for the FPU bank
package fpu_bank_pkg;

  localparam int MAX_LANES   = 16;
  localparam int DEF_ADDR_W  = 23;
  localparam int DEF_OP_W    = 4;
  localparam int DEF_TAG_W   = 4;

  localparam logic [DEF_OP_W-1:0] OP_LINEAR_FW = 4'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lane_state_t;

  typedef struct packed {
    logic [DEF_OP_W-1:0]   op;
    logic [DEF_ADDR_W-1:0] a;
    logic [DEF_ADDR_W-1:0] b;
    logic [DEF_ADDR_W-1:0] c;
    logic [DEF_ADDR_W-1:0] d;
  } job_desc_t;

  typedef logic [DEF_TAG_W-1:0] job_tag_t;

  // Returns {found, index} of the first set bit at or after start, wrapping at n.
  function automatic logic [4:0] find_first_from(input logic [MAX_LANES-1:0] mask,
                                                 input int start, input int n);
    logic [4:0] r;
    int idx;
    r = '0;
    for (int i = MAX_LANES - 1; i >= 0; i--) begin
      if (i < n) begin
        idx = (start + i) % n;
        if (mask[idx]) r = {1'b1, idx[3:0]};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fpu_job_fifo.sv
// rtl/fpu_job_fifo.sv - synchronous FIFO holding queued FPU jobs
module fpu_job_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/fpu_bank_array.sv
// rtl/fpu_bank_array.sv - job queue with round-robin dispatch to NUM_LANES FPU job managers
// FPU_BANK_PERF_CNT_EN adds saturating completion and busy-cycle counters.
module fpu_bank_array
  import fpu_bank_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int QDEPTH    = 8,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int OP_W      = DEF_OP_W,
  parameter int TAG_W     = DEF_TAG_W,
  localparam int DESC_W   = OP_W + 4 * ADDR_W,
  localparam int LW       = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
  localparam int CW       = $clog2(QDEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        job_avail,
  output logic                        job_accept,
  input  logic [OP_W-1:0]             job_op,
  input  logic [TAG_W-1:0]            job_tag,
  input  logic [ADDR_W-1:0]           job_a,
  input  logic [ADDR_W-1:0]           job_b,
  input  logic [ADDR_W-1:0]           job_c,
  input  logic [ADDR_W-1:0]           job_d,
  output logic [NUM_LANES-1:0]        lane_start,
  output logic [NUM_LANES*DESC_W-1:0] lane_desc,
  input  logic [NUM_LANES-1:0]        lane_done,
  output logic                        cmpl_valid,
  output logic [TAG_W-1:0]            cmpl_tag,
  output logic [LW-1:0]               cmpl_lane,
  input  logic                        cmpl_ready,
  output logic [CW-1:0]               queue_count,
  output logic                        bank_idle,
  output logic                        err_spurious
`ifdef FPU_BANK_PERF_CNT_EN
  ,
  output logic [31:0]                 perf_jobs_done,
  output logic [31:0]                 perf_busy_cycles
`endif
);

  localparam int FW = TAG_W + DESC_W;

  lane_state_t            lane_st  [NUM_LANES];
  logic [TAG_W-1:0]       lane_tag [NUM_LANES];
  logic [LW-1:0]          disp_ptr;
  logic [LW-1:0]          cmpl_ptr;
  logic [NUM_LANES-1:0]   idle_mask;
  logic [NUM_LANES-1:0]   done_mask;
  logic [MAX_LANES-1:0]   idle_ext;
  logic [MAX_LANES-1:0]   done_ext;
  logic [4:0]             disp_pick;
  logic [4:0]             cmpl_pick;
  logic [LW-1:0]          disp_lane;
  logic [FW-1:0]          head;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic                   do_pop;
  logic                   cmpl_fire;

  function automatic logic [LW-1:0] wrap_inc(input logic [LW-1:0] x);
    return (int'(x) == NUM_LANES - 1) ? '0 : x + 1'b1;
  endfunction

  fpu_job_fifo #(
    .WIDTH (FW),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (job_avail),
    .push_data ({job_tag, job_op, job_a, job_b, job_c, job_d}),
    .pop       (do_pop),
    .pop_data  (head),
    .count     (queue_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    idle_mask = '0;
    done_mask = '0;
    idle_ext  = '0;
    done_ext  = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      idle_mask[i] = (lane_st[i] == IDLE);
      done_mask[i] = (lane_st[i] == DONE);
    end
    idle_ext[NUM_LANES-1:0] = idle_mask;
    done_ext[NUM_LANES-1:0] = done_mask;
    disp_pick = find_first_from(idle_ext, int'(disp_ptr), NUM_LANES);
    cmpl_pick = find_first_from(done_ext, int'(cmpl_ptr), NUM_LANES);
  end

  assign disp_lane  = disp_pick[LW-1:0];
  assign do_pop     = !fifo_empty && disp_pick[4];
  assign job_accept = !fifo_full;
  assign bank_idle  = fifo_empty && (&idle_mask);
  assign cmpl_valid = cmpl_pick[4];
  assign cmpl_lane  = cmpl_pick[LW-1:0];
  assign cmpl_tag   = lane_tag[cmpl_lane];
  assign cmpl_fire  = cmpl_valid && cmpl_ready;

  // While a completion waits, cmpl_ptr parks on it so a newly finished lane
  // earlier in the rotation cannot displace the one already offered.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_ptr     <= '0;
      cmpl_ptr     <= '0;
      lane_start   <= '0;
      err_spurious <= 1'b0;
    end else begin
      lane_start <= '0;
      if (do_pop) begin
        lane_start[disp_lane] <= 1'b1;
        disp_ptr              <= wrap_inc(disp_lane);
      end
      if (cmpl_fire)       cmpl_ptr <= wrap_inc(cmpl_lane);
      else if (cmpl_valid) cmpl_ptr <= cmpl_lane;
      for (int i = 0; i < NUM_LANES; i++) begin
        if (lane_done[i] && (lane_st[i] != BUSY)) err_spurious <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_desc <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        lane_st[i]  <= IDLE;
        lane_tag[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        case (lane_st[i])
          IDLE: if (do_pop && (disp_lane == LW'(i))) begin
            lane_st[i]                      <= BUSY;
            lane_desc[i*DESC_W +: DESC_W]   <= head[DESC_W-1:0];
            lane_tag[i]                     <= head[FW-1:DESC_W];
          end
          BUSY: if (lane_done[i]) lane_st[i] <= DONE;
          DONE: if (cmpl_fire && (cmpl_lane == LW'(i))) lane_st[i] <= IDLE;
          default: lane_st[i] <= IDLE;
        endcase
      end
    end
  end

`ifdef FPU_BANK_PERF_CNT_EN
  logic any_busy;

  always_comb begin
    any_busy = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (lane_st[i] == BUSY) any_busy = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_jobs_done   <= '0;
      perf_busy_cycles <= '0;
    end else begin
      if (cmpl_fire && (perf_jobs_done != '1))  perf_jobs_done   <= perf_jobs_done + 1'b1;
      if (any_busy && (perf_busy_cycles != '1)) perf_busy_cycles <= perf_busy_cycles + 1'b1;
    end
  end
`endif

endmodule
